// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice with a registered carry, LSB-first over WIDTH cycles.
// Optional SERIAL_ADD_OVF_EN adds a held two's-complement overflow output (ovf).
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [WIDTH-1:0] sum_q,    sum_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic             carry_q,  carry_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic             cout_q,   cout_d;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_q,    ovf_d;
`endif

   logic bit_s;
   logic carry_nxt;
   logic last_bit;

   always_comb begin
      bit_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
      carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
      last_bit  = (cnt_q == CW'(WIDTH - 1));

      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d    = ovf_q;
`endif

      case (state_q)
         // The DONE cycle also serves as an accept slot, so back-to-back ops run every WIDTH+1 cycles.
         IDLE, DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_sh_d = (res_sh_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
            carry_d  = carry_nxt;
            cnt_d    = cnt_q + CW'(1);
            if (last_bit) begin
               sum_d   = res_sh_d;
               cout_d  = carry_nxt;
`ifdef SERIAL_ADD_OVF_EN
               ovf_d   = carry_q ^ carry_nxt;
`endif
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         sum_q    <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         sum_q    <= sum_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cout_q   <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule
